// File: rtl/fnd_scan_ctrl.sv
// Multiplexed N-digit seven-segment scan controller with frame-synchronous data loading.
// Latency: all outputs are registered; a new digit appears 1 clk after the index moves. A load reaches the display at the next frame.
// Backpressure: none. i_load is always accepted, and the last load before a frame wrap wins.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   i_bcd        packed BCD, digit k at [4k+3:4k], digit 0 rightmost
//   i_dp         decimal point per digit (1 = lit)
//   i_blink      blink mask per digit
//   i_lzb        leading-zero blanking enable (used live, not captured)
//   i_load       capture request for i_bcd / i_dp / i_blink into the pending buffer
//   o_seg        segments {a,b,c,d,e,f,g}, polarity per SEG_ACTIVE_LOW
//   o_seg_dp     decimal point, polarity per SEG_ACTIVE_LOW
//   o_seg_enb    one-hot digit select, polarity per ENB_ACTIVE_LOW
//   o_frame      one-cycle pulse coincident with the first digit-0 slot of a frame
module fnd_scan_ctrl #(
  parameter int DIGITS         = 6,
  parameter int SCAN_DIV       = 50000,
  parameter int BLINK_TICKS    = 500,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit ENB_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   i_bcd,
  input  logic [DIGITS-1:0]     i_dp,
  input  logic [DIGITS-1:0]     i_blink,
  input  logic                  i_lzb,
  input  logic                  i_load,
  output logic [6:0]            o_seg,
  output logic                  o_seg_dp,
  output logic [DIGITS-1:0]     o_seg_enb,
  output logic                  o_frame
);

  // Counter widths. SCAN_DIV >= 2 always gives at least one prescaler bit.
  // The other two counters are floored at one bit.
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_TICKS - 1);

  // Inactive levels. XOR with these converts active-high internal values to pin polarity.
  localparam logic [6:0]        SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic              DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [DIGITS-1:0] ENB_OFF = ENB_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [PW-1:0]         presc;
  logic [IW-1:0]         idx;
  logic [BW-1:0]         blink_cnt;
  logic                  blink_phase;
  logic                  tick;
  logic                  wrap;
  logic                  wrap_q;

  logic [4*DIGITS-1:0]   pend_bcd;
  logic [DIGITS-1:0]     pend_dp;
  logic [DIGITS-1:0]     pend_blink;
  logic                  pend_vld;

  logic [4*DIGITS-1:0]   act_bcd;
  logic [DIGITS-1:0]     act_dp;
  logic [DIGITS-1:0]     act_blink;

  logic [3:0]            cur_bcd;
  logic                  cur_dp;
  logic                  cur_blink;
  logic                  upper_zero;
  logic                  lz_blank;
  logic                  blank;
  logic [6:0]            seg_raw;
  logic                  dp_raw;
  logic [DIGITS-1:0]     enb_hot;

  // Active-high segment pattern {a..g}. Codes 10..15 show a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
    logic [6:0] s;
    case (bcd)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1110011;
      default: s = 7'b0000001;
    endcase
    return s;
  endfunction

  // Scan timing: prescaler -> digit index -> blink counter.
  assign tick = (presc == PRESC_MAX);
  assign wrap = tick && (idx == IDX_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (tick) begin
      idx <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (tick) begin
      if (blink_cnt == BLINK_MAX) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  // Double buffer. The active set only changes on a frame wrap, so a frame never mixes old and new data.
  // When a load lands on the wrap itself, the previous pending set is promoted first.
  // The new data then stays pending, so pend_vld remains set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_bcd   <= '0;
      pend_dp    <= '0;
      pend_blink <= '0;
      pend_vld   <= 1'b0;
      act_bcd    <= '0;
      act_dp     <= '0;
      act_blink  <= '0;
    end else begin
      if (wrap && pend_vld) begin
        act_bcd   <= pend_bcd;
        act_dp    <= pend_dp;
        act_blink <= pend_blink;
        pend_vld  <= 1'b0;
      end
      if (i_load) begin
        pend_bcd   <= i_bcd;
        pend_dp    <= i_dp;
        pend_blink <= i_blink;
        pend_vld   <= 1'b1;
      end
    end
  end

  // Select the current digit and work out leading-zero status in one pass from the most significant digit down.
  // upper_zero is true while every digit from k up to the top is zero.
  always_comb begin
    cur_bcd    = 4'd0;
    cur_dp     = 1'b0;
    cur_blink  = 1'b0;
    upper_zero = 1'b1;
    lz_blank   = 1'b0;
    enb_hot    = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      upper_zero = upper_zero && (act_bcd[4*k +: 4] == 4'd0);
      if (idx == IW'(k)) begin
        cur_bcd    = act_bcd[4*k +: 4];
        cur_dp     = act_dp[k];
        cur_blink  = act_blink[k];
        lz_blank   = (k != 0) && upper_zero;
        enb_hot[k] = 1'b1;
      end
    end
  end

  always_comb begin
    blank   = (i_lzb && lz_blank) || (blink_phase && cur_blink);
    seg_raw = blank ? 7'b0000000 : seg_decode(cur_bcd);
    dp_raw  = cur_dp && !blank;
  end

  // Output stage. Registering the digit select together with the segments keeps them aligned.
  // o_frame is delayed by two flops so it lines up with the first registered digit-0 slot of the new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_seg     <= SEG_OFF;
      o_seg_dp  <= DP_OFF;
      o_seg_enb <= ENB_OFF;
      wrap_q    <= 1'b0;
      o_frame   <= 1'b0;
    end else begin
      o_seg     <= seg_raw ^ SEG_OFF;
      o_seg_dp  <= dp_raw ^ DP_OFF;
      o_seg_enb <= enb_hot ^ ENB_OFF;
      wrap_q    <= wrap;
      o_frame   <= wrap_q;
    end
  end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
module tb_fnd_scan_ctrl;

  localparam int D   = 4;
  localparam int SD  = 4;
  localparam int BT  = 2;
  localparam int FRM = D * SD;

  logic        clk;
  logic        rst_n;
  logic [15:0] i_bcd;
  logic [3:0]  i_dp;
  logic [3:0]  i_blink;
  logic        i_lzb;
  logic        i_load;
  logic [6:0]  o_seg;
  logic        o_seg_dp;
  logic [3:0]  o_seg_enb;
  logic        o_frame;

  fnd_scan_ctrl #(
    .DIGITS(D), .SCAN_DIV(SD), .BLINK_TICKS(BT),
    .SEG_ACTIVE_LOW(1'b0), .ENB_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_bcd(i_bcd), .i_dp(i_dp), .i_blink(i_blink),
    .i_lzb(i_lzb), .i_load(i_load), .o_seg(o_seg), .o_seg_dp(o_seg_dp),
    .o_seg_enb(o_seg_enb), .o_frame(o_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  // t is the number of clock edges taken since reset release, so the edge about to be taken is number t+1.
  int          t;
  logic [15:0] m_act_bcd, m_pend_bcd;
  logic [3:0]  m_act_dp, m_pend_dp, m_act_blk, m_pend_blk;
  bit          m_pflag;
  bit          lzb_cur;
  logic [6:0]  seg_tab [16];

  logic [12:0] exp_q [$];
  bit          mon_en;
  int          checks;
  int          errors;

  // Expected {seg, dp, enb, frame} registered at the next edge.
  // It is computed from elapsed time, not from counters.
  function automatic logic [12:0] model_out(input bit lzb);
    int         slot;
    int         k;
    bit         phase;
    bit         blank;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] enb;
    logic [3:0] one;
    bit         frame;
    slot  = t / SD;
    k     = slot % D;
    phase = ((slot / BT) % 2) == 1;
    blank = (phase && m_act_blk[k]) || (lzb && k >= 1 && ((m_act_bcd >> (4 * k)) == 16'd0));
    seg   = blank ? 7'b0000000 : seg_tab[m_act_bcd[4*k +: 4]];
    dp    = m_act_dp[k] && !blank;
    one   = 4'b0001;
    enb   = ~(one << k);
    frame = (t > 0) && (t % FRM == 0);
    return {seg, dp, enb, frame};
  endfunction

  task automatic model_reset();
    t          = 0;
    m_act_bcd  = '0; m_act_dp  = '0; m_act_blk  = '0;
    m_pend_bcd = '0; m_pend_dp = '0; m_pend_blk = '0;
    m_pflag    = 1'b0;
  endtask

  // Take one clock edge with the given load request, then hand the expectation to the monitor.
  task automatic step(input bit ld, input logic [15:0] bcd, input logic [3:0] dp, input logic [3:0] blk);
    logic [12:0] e;
    i_load  = ld;
    i_bcd   = bcd;
    i_dp    = dp;
    i_blink = blk;
    i_lzb   = lzb_cur;
    e = model_out(lzb_cur);
    // The last edge of every frame promotes pending data, and then a load on that same edge refills pending.
    if ((t % FRM) == FRM - 1 && m_pflag) begin
      m_act_bcd = m_pend_bcd; m_act_dp = m_pend_dp; m_act_blk = m_pend_blk;
      m_pflag   = 1'b0;
    end
    if (ld) begin
      m_pend_bcd = bcd; m_pend_dp = dp; m_pend_blk = blk;
      m_pflag    = 1'b1;
    end
    t++;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
    i_load = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 4'h0, 4'h0);
  endtask

  task automatic wait_phase(input int ph);
    while ((t % FRM) != ph) step(1'b0, 16'h0000, 4'h0, 4'h0);
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (o_seg !== 7'b0000000 || o_seg_dp !== 1'b0 || o_seg_enb !== 4'b1111 || o_frame !== 1'b0) begin
      errors++;
      $display("FAIL %s: got seg=%b dp=%b enb=%b frm=%b, need seg=0000000 dp=0 enb=1111 frm=0",
               name, o_seg, o_seg_dp, o_seg_enb, o_frame);
    end
  endtask

  // Monitor: one registered output per edge, compared on the falling edge.
  always @(negedge clk) begin
    logic [12:0] e;
    logic [12:0] a;
    if (mon_en && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {o_seg, o_seg_dp, o_seg_enb, o_frame};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL scan @%0t: got seg=%b dp=%b enb=%b frm=%b, need seg=%b dp=%b enb=%b frm=%b",
                 $time, a[12:6], a[5], a[4:1], a[0], e[12:6], e[5], e[4:1], e[0]);
      end
    end
  end

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    int          r;
    v = '0;
    for (int k = 0; k < 4; k++) begin
      r = $urandom_range(0, 9);
      if (r < 4)       v[4*k +: 4] = 4'd0;
      else if (r == 9) v[4*k +: 4] = 4'($urandom_range(10, 15));
      else             v[4*k +: 4] = 4'($urandom_range(0, 9));
    end
    return v;
  endfunction

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 49) == 0) lzb_cur = ~lzb_cur;
      if ($urandom_range(0, 19) == 0)
        step(1'b1, rand_bcd(), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      else
        step(1'b0, 16'h0000, 4'h0, 4'h0);
    end
  endtask

  initial begin
    seg_tab[0]  = 7'b1111110; seg_tab[1]  = 7'b0110000; seg_tab[2]  = 7'b1101101;
    seg_tab[3]  = 7'b1111001; seg_tab[4]  = 7'b0110011; seg_tab[5]  = 7'b1011011;
    seg_tab[6]  = 7'b1011111; seg_tab[7]  = 7'b1110000; seg_tab[8]  = 7'b1111111;
    seg_tab[9]  = 7'b1110011;
    for (int k = 10; k < 16; k++) seg_tab[k] = 7'b0000001;

    checks = 0; errors = 0; mon_en = 1'b0; lzb_cur = 1'b0;
    i_bcd = '0; i_dp = '0; i_blink = '0; i_lzb = 1'b0; i_load = 1'b0;
    model_reset();

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("reset_init");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;

    // Free scan of zeros: enable rotation, a 16-cycle frame pulse, digit shows '0'.
    idle(40);

    // Load in mid-frame. Nothing may change until the frame wrap.
    wait_phase(5);
    step(1'b1, 16'h1234, 4'h0, 4'h0);
    idle(40);

    // Leading-zero blanking.
    lzb_cur = 1'b1;
    step(1'b1, 16'h0007, 4'h0, 4'h0);
    idle(40);
    step(1'b1, 16'h0000, 4'h0, 4'h0);
    idle(40);

    // Blink on digit 1.
    lzb_cur = 1'b0;
    step(1'b1, 16'h5555, 4'h0, 4'b0010);
    idle(80);

    // Load on the wrap edge while a different load is pending, plus an invalid BCD code.
    wait_phase(4);
    step(1'b1, 16'h1111, 4'h0, 4'h0);
    wait_phase(FRM - 1);
    step(1'b1, 16'hA000, 4'h0, 4'h0);
    idle(40);

    // Decimal points, with blanking interacting with dp.
    lzb_cur = 1'b1;
    step(1'b1, 16'h0096, 4'b1111, 4'b0001);
    idle(48);
    lzb_cur = 1'b0;

    random_run(1500);

    // Reset during digit 2 with a load still pending.
    lzb_cur = 1'b0;
    wait_phase(2);
    step(1'b1, 16'h4321, 4'hF, 4'h0);
    wait_phase(9);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset_mid_async");
    exp_q.delete();
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset_mid_held");
    rst_n  = 1'b1;
    mon_en = 1'b1;
    idle(40);

    random_run(300);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
